// File: rtl/cbfp_denorm_pkg.sv
// Shared FFT stage-0 parameters used by the CBFP denormalizer.
// Also provides the counter width helper used for the block position output.
package cbfp_denorm_pkg;

   localparam int FFT_N               = 16;
   localparam int FFT_IDX_WIDTH       = 5;
   localparam int FFT_TOTAL_BLOCK_CNT = 32;
   localparam int FFT_NORM_WIDTH      = 11;
   localparam int FFT_REST_WIDTH      = 23;
   localparam int FFT_SHIFT_BASE      = 12;

   // A one-block frame still needs a 1-bit counter port.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cbfp_lane_shift.sv
// One complex lane of the CBFP restore: widen, shift up by SHIFT_BASE, then
// arithmetic right shift by the lane's block exponent. Purely combinational.
module cbfp_lane_shift #(
   parameter int IN_BIT_WIDTH  = 11,
   parameter int OUT_BIT_WIDTH = 23,
   parameter int IDX_WIDTH     = 5,
   parameter int SHIFT_BASE    = 12
) (
   input  logic signed [IN_BIT_WIDTH-1:0]  re_i,
   input  logic signed [IN_BIT_WIDTH-1:0]  im_i,
   input  logic        [IDX_WIDTH-1:0]     idx_i,
   output logic signed [OUT_BIT_WIDTH-1:0] re_o,
   output logic signed [OUT_BIT_WIDTH-1:0] im_o
);

   logic signed [OUT_BIT_WIDTH-1:0] re_ext;
   logic signed [OUT_BIT_WIDTH-1:0] im_ext;
   logic                            idx_ovf;

   assign re_ext  = OUT_BIT_WIDTH'(re_i) <<< SHIFT_BASE;
   assign im_ext  = OUT_BIT_WIDTH'(im_i) <<< SHIFT_BASE;
   assign idx_ovf = (32'(idx_i) >= 32'(OUT_BIT_WIDTH));

   // Exponents past the word width collapse to pure sign fill (0 or -1).
   always_comb begin
      re_o = re_ext >>> idx_i;
      im_o = im_ext >>> idx_i;
      if (idx_ovf) begin
         re_o = {OUT_BIT_WIDTH{re_ext[OUT_BIT_WIDTH-1]}};
         im_o = {OUT_BIT_WIDTH{im_ext[OUT_BIT_WIDTH-1]}};
      end
   end

endmodule

// File: rtl/cbfp_denorm.sv
// CBFP denormalizer: restores N complex lanes per block with a 2-cycle pipeline,
// tracks block position within a frame and the per-frame maximum exponent.
module cbfp_denorm
   import cbfp_denorm_pkg::*;
#(
   parameter int IN_BIT_WIDTH    = FFT_NORM_WIDTH,
   parameter int OUT_BIT_WIDTH   = FFT_REST_WIDTH,
   parameter int N               = FFT_N,
   parameter int IDX_WIDTH       = FFT_IDX_WIDTH,
   parameter int SHIFT_BASE      = FFT_SHIFT_BASE,
   parameter int TOTAL_BLOCK_CNT = FFT_TOTAL_BLOCK_CNT
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic                                      valid_in,
   input  logic signed [IN_BIT_WIDTH-1:0]            din_i [0:N-1],
   input  logic signed [IN_BIT_WIDTH-1:0]            din_q [0:N-1],
   input  logic        [IDX_WIDTH-1:0]               cbfp_index [0:N-1],
   output logic                                      valid_out,
   output logic signed [OUT_BIT_WIDTH-1:0]           dout_i [0:N-1],
   output logic signed [OUT_BIT_WIDTH-1:0]           dout_q [0:N-1],
   output logic [cnt_width(TOTAL_BLOCK_CNT)-1:0]     blk_cnt,
   output logic                                      frame_done,
   output logic        [IDX_WIDTH-1:0]               frame_max_idx
);

   localparam int                 CNT_W    = cnt_width(TOTAL_BLOCK_CNT);
   localparam logic [CNT_W-1:0]   LAST_POS = CNT_W'(TOTAL_BLOCK_CNT - 1);

   logic                 valid_s1_q;
   logic [IDX_WIDTH-1:0] idx_s1 [0:N-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) valid_s1_q <= 1'b0;
      else       valid_s1_q <= valid_in;
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic signed [IN_BIT_WIDTH-1:0]  din_i_s1_q;
      logic signed [IN_BIT_WIDTH-1:0]  din_q_s1_q;
      logic        [IDX_WIDTH-1:0]     idx_s1_q;
      logic signed [OUT_BIT_WIDTH-1:0] shift_i;
      logic signed [OUT_BIT_WIDTH-1:0] shift_q;
      logic signed [OUT_BIT_WIDTH-1:0] dout_i_q;
      logic signed [OUT_BIT_WIDTH-1:0] dout_q_q;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            din_i_s1_q <= '0;
            din_q_s1_q <= '0;
            idx_s1_q   <= '0;
         end else if (valid_in) begin
            din_i_s1_q <= din_i[gi];
            din_q_s1_q <= din_q[gi];
            idx_s1_q   <= cbfp_index[gi];
         end
      end

      cbfp_lane_shift #(
         .IN_BIT_WIDTH  (IN_BIT_WIDTH),
         .OUT_BIT_WIDTH (OUT_BIT_WIDTH),
         .IDX_WIDTH     (IDX_WIDTH),
         .SHIFT_BASE    (SHIFT_BASE)
      ) u_shift (
         .re_i  (din_i_s1_q),
         .im_i  (din_q_s1_q),
         .idx_i (idx_s1_q),
         .re_o  (shift_i),
         .im_o  (shift_q)
      );

      // Outputs only move on a valid block so they hold across bubbles.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            dout_i_q <= '0;
            dout_q_q <= '0;
         end else if (valid_s1_q) begin
            dout_i_q <= shift_i;
            dout_q_q <= shift_q;
         end
      end

      assign idx_s1[gi] = idx_s1_q;
      assign dout_i[gi] = dout_i_q;
      assign dout_q[gi] = dout_q_q;
   end

   logic [IDX_WIDTH-1:0] blk_max;
   logic [IDX_WIDTH-1:0] merged_max;

   always_comb begin
      blk_max = '0;
      for (int li = 0; li < N; li++) begin
         if (idx_s1[li] > blk_max) blk_max = idx_s1[li];
      end
   end

   logic                 valid_out_q, valid_out_d;
   logic                 frame_done_q, frame_done_d;
   logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0]     next_pos_q, next_pos_d;
   logic [IDX_WIDTH-1:0] run_max_q, run_max_d;
   logic [IDX_WIDTH-1:0] frame_max_q, frame_max_d;

   // next_pos_q is the frame slot the next valid block will occupy.
   always_comb begin
      valid_out_d  = valid_s1_q;
      frame_done_d = valid_s1_q && (next_pos_q == LAST_POS);
      blk_cnt_d    = blk_cnt_q;
      next_pos_d   = next_pos_q;
      run_max_d    = run_max_q;
      frame_max_d  = frame_max_q;
      merged_max   = (blk_max > run_max_q) ? blk_max : run_max_q;
      if (valid_s1_q) begin
         blk_cnt_d = next_pos_q;
         if (next_pos_q == LAST_POS) begin
            next_pos_d  = '0;
            frame_max_d = merged_max;
            run_max_d   = '0;
         end else begin
            next_pos_d = next_pos_q + 1'b1;
            run_max_d  = merged_max;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         blk_cnt_q    <= '0;
         next_pos_q   <= '0;
         run_max_q    <= '0;
         frame_max_q  <= '0;
      end else begin
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
         blk_cnt_q    <= blk_cnt_d;
         next_pos_q   <= next_pos_d;
         run_max_q    <= run_max_d;
         frame_max_q  <= frame_max_d;
      end
   end

   assign valid_out     = valid_out_q;
   assign frame_done    = frame_done_q;
   assign blk_cnt       = blk_cnt_q;
   assign frame_max_idx = frame_max_q;

endmodule
